// File: rtl/ex06_pkg.sv
// ex06_pkg: shared constants and state encoding for the ex06 sequential divider.
//   DVD_W / DVS_W : default dividend/quotient and divisor/remainder widths
//   ITERS         : one trial subtraction per dividend bit
//   CNT_W         : width of the iteration counter
package ex06_pkg;

  localparam int unsigned DVD_W = 8;
  localparam int unsigned DVS_W = 4;
  localparam int unsigned ITERS = DVD_W;
  localparam int unsigned CNT_W = $clog2(ITERS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (combinational).
//   pr_i      : partial remainder before this step (DVS_W+1 bits)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   pr_o      : partial remainder after the trial subtraction
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int unsigned DVS_W = 4
) (
  input  logic [DVS_W:0]   pr_i,
  input  logic             bit_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVS_W:0]   pr_o,
  output logic             q_o
);

  logic [DVS_W+1:0] trial;
  logic [DVS_W+1:0] dvs_ext;

  always_comb begin
    // Full-width shift so no bit of pr_i is discarded before the compare.
    trial   = {pr_i, bit_i};
    dvs_ext = {2'b00, divisor_i};
    if (trial >= dvs_ext) begin
      pr_o = (DVS_W+1)'(trial - dvs_ext);
      q_o  = 1'b1;
    end else begin
      pr_o = trial[DVS_W:0];
      q_o  = 1'b0;
    end
  end

endmodule

// File: rtl/ex06_seqdiv.sv
// ex06_seqdiv: sequential restoring divider, one trial subtraction per cycle.
//   clk, rst      : clock and synchronous active-high reset
//   start         : request, accepted only while idle and not busy
//   dividend      : numerator, captured on the accepted start
//   divisor       : denominator, captured on the accepted start
//   quotient      : result, held until the next completion
//   remainder     : result, held until the next completion
//   busy          : division in progress
//   done          : one-cycle completion pulse
//   div_by_zero   : last accepted divisor was zero
module ex06_seqdiv
  import ex06_pkg::*;
#(
  parameter int unsigned DVD_W = ex06_pkg::DVD_W,
  parameter int unsigned DVS_W = ex06_pkg::DVS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned ITER_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [DVD_W-1:0]    dvd_q, dvd_d;
  logic [DVS_W-1:0]    dvs_q, dvs_d;
  logic [DVS_W:0]      pr_q, pr_d;
  logic [DVD_W-1:0]    quo_q, quo_d;
  logic [DVS_W-1:0]    rem_q, rem_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic [DVS_W:0]      step_pr;
  logic                step_q;

  div_step #(
    .DVS_W(DVS_W)
  ) u_step (
    .pr_i      (pr_q),
    .bit_i     (dvd_q[DVD_W-1]),
    .divisor_i (dvs_q),
    .pr_o      (step_pr),
    .q_o       (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (busy_q) begin
          // Busy while idle only happens the cycle after a zero-divisor start.
          quo_d  = '1;
          rem_d  = '1;
          dbz_d  = 1'b1;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          pr_d   = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (divisor != '0) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // Dividend bits leave at the MSB while quotient bits enter at the LSB,
        // so after the last step this register holds the quotient.
        dvd_d = {dvd_q[DVD_W-2:0], step_q};
        pr_d  = step_pr;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_W'(DVD_W - 1)) begin
          quo_d   = {dvd_q[DVD_W-2:0], step_q};
          rem_d   = step_pr[DVS_W-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex06_seqdiv.sv
module tb_ex06_seqdiv;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  ex06_seqdiv #(
    .DVD_W(8),
    .DVS_W(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus driver: issues one request and waits (bounded) for done.
  // lat = number of edges from the accepting edge to the edge that raised done.
  // bok = busy was high on every sample before done and low on the done sample.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r,
                         output logic z, output int lat, output bit bok);
    int n;
    n   = 0;
    bok = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (!done && !busy) bok = 1'b0;
      if (done && busy) bok = 1'b0;
    end while (!done && n < 30);
    q   = quotient;
    r   = remainder;
    z   = div_by_zero;
    lat = n - 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_q got %0d exp 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_r got %0d exp 0", remainder); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] q; logic [3:0] r; logic z; int lat; bit bok;
    run_div(8'd12, 4'd6, q, r, z, lat, bok);
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
    checks++; if (!bok) begin errors++; $display("FAIL basic_busy got bad-window exp busy k..k+8"); end
    checks++; if (q !== 8'd2) begin errors++; $display("FAIL basic_q got %0d exp 2", q); end
    checks++; if (r !== 4'd0) begin errors++; $display("FAIL basic_r got %0d exp 0", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b exp 0", z); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
    checks++; if (quotient !== 8'd2) begin errors++; $display("FAIL basic_hold_q got %0d exp 2", quotient); end
  endtask

  task automatic test_vectors;
    logic [7:0] va [4] = '{8'd200, 8'd3, 8'd255, 8'd225};
    logic [3:0] vb [4] = '{4'd7, 4'd9, 4'd1, 4'd15};
    logic [7:0] eq [4] = '{8'd28, 8'd0, 8'd255, 8'd15};
    logic [3:0] er [4] = '{4'd4, 4'd3, 4'd0, 4'd0};
    logic [7:0] q; logic [3:0] r; logic z; int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], q, r, z, lat, bok);
      checks++;
      if (q !== eq[i] || r !== er[i] || lat != 8 || z !== 1'b0) begin
        errors++;
        $display("FAIL vec_%0d_%0d got q=%0d r=%0d lat=%0d dbz=%b exp q=%0d r=%0d lat=8 dbz=0",
                 va[i], vb[i], q, r, lat, z, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [7:0] q; logic [3:0] r; logic z; int lat; bit bok;
    run_div(8'd5, 4'd0, q, r, z, lat, bok);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d exp 1", lat); end
    checks++; if (!bok) begin errors++; $display("FAIL dz_busy got bad-window exp one-cycle busy"); end
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dz_q got %h exp ff", q); end
    checks++; if (r !== 4'hF) begin errors++; $display("FAIL dz_r got %h exp f", r); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", z); end
    run_div(8'd8, 4'd4, q, r, z, lat, bok);
    checks++;
    if (q !== 8'd2 || r !== 4'd0 || z !== 1'b0 || lat != 8) begin
      errors++;
      $display("FAIL dz_recover got q=%0d r=%0d dbz=%b lat=%0d exp q=2 r=0 dbz=0 lat=8", q, r, z, lat);
    end
  endtask

  // start held high with operands churning; a start in the done cycle chains.
  task automatic test_back_to_back;
    int n = 0, nd = 0, t1 = 0, t2 = 0, both = 0, wide = 0;
    logic prev_done = 1'b0;
    bit drop = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (drop) begin start = 1'b0; drop = 1'b0; end
      if (done && busy) both++;
      if (done && prev_done) wide++;
      prev_done = done;
      if (done) begin
        nd++;
        if (nd == 1) begin
          t1 = n;
          checks++;
          if (quotient !== 8'd33 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL b2b_first got q=%0d r=%0d exp q=33 r=1", quotient, remainder);
          end
          dividend = 8'd50;
          divisor  = 4'd5;
          drop     = 1'b1;
        end else if (nd == 2) begin
          t2 = n;
          checks++;
          if (quotient !== 8'd10 || remainder !== 4'd0) begin
            errors++;
            $display("FAIL b2b_second got q=%0d r=%0d exp q=10 r=0", quotient, remainder);
          end
        end
      end else begin
        dividend = 8'($urandom);
        divisor  = 4'($urandom_range(1, 15));
      end
    end
    start = 1'b0;
    checks++; if (t1 != 9) begin errors++; $display("FAIL b2b_t1 got %0d exp 9", t1); end
    checks++; if (t2 - t1 != 9) begin errors++; $display("FAIL b2b_spacing got %0d exp 9", t2 - t1); end
    checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", nd); end
    checks++; if (both != 0) begin errors++; $display("FAIL b2b_done_busy got %0d exp 0", both); end
    checks++; if (wide != 0) begin errors++; $display("FAIL b2b_done_wide got %0d exp 0", wide); end
  endtask

  task automatic test_reset_abort;
    int nd = 0;
    logic [7:0] q; logic [3:0] r; logic z; int lat; bit bok;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL abort_q got %0d exp 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL abort_r got %0d exp 0", remainder); end
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", nd); end
    run_div(8'd100, 4'd3, q, r, z, lat, bok);
    checks++;
    if (q !== 8'd33 || r !== 4'd1 || lat != 8) begin
      errors++;
      $display("FAIL abort_rerun got q=%0d r=%0d lat=%0d exp q=33 r=1 lat=8", q, r, lat);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] q; logic [3:0] r; logic z; int lat; bit bok;
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        run_div(8'(a * b), 4'(b), q, r, z, lat, bok);
        checks++;
        if (q !== 8'(a) || r !== 4'd0 || lat != 8 || !bok) begin
          errors++;
          $display("FAIL sweep_%0dx%0d got q=%0d r=%0d lat=%0d exp q=%0d r=0 lat=8", a, b, q, r, lat, a);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset;
    test_basic;
    test_vectors;
    test_div_zero;
    test_back_to_back;
    test_reset_abort;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
